fxp_mul_arbiter: RTL and testbench

- Shares one signed Q4.4 x Q4.4 multiplier between NREQ requesters using round-robin arbitration.
- Each request is a valid/ready operand handshake. Each result is returned through a single valid/ready response channel, tagged with the requester index.
- Sits in front of the fixed-point datapath, so several producers can use one multiplier without contention.

---
 rtl/fxp_pkg.sv | 36 +++
 rtl/fxp_q44_mul_core.sv | 25 ++
 rtl/fxp_mul_arbiter.sv | 116 +++++++++++
 tb/tb_fxp_mul_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared constants, FSM state type and round-robin grant helper for the
// fixed-point multiplier arbiter.
package fxp_pkg;

    localparam int unsigned FXP_W    = 8;
    localparam int unsigned FXP_FRAC = 4;
    localparam int unsigned MAX_REQ  = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    // First valid index searching upward from last+1, wrapping at nreq.
    function automatic logic [1:0] rr_next(
        input logic [MAX_REQ-1:0] valid,
        input logic [1:0]         last,
        input int unsigned        nreq
    );
        logic [1:0]  pick;
        logic        found;
        int unsigned j;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            j = (32'(last) + k) % nreq;
            if (k <= nreq && !found && valid[j]) begin
                pick  = 2'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fxp_q44_mul_core.sv
// Combinational signed Q4.4 x Q4.4 multiply, rounded half away from zero to
// an 8-bit signed integer.
module fxp_q44_mul_core
    import fxp_pkg::*;
(
    input  logic [FXP_W-1:0] a,
    input  logic [FXP_W-1:0] b,
    output logic [FXP_W-1:0] y
);

    logic signed [2*FXP_W-1:0] w_p;
    logic        [2*FXP_W-1:0] w_m;
    logic        [FXP_W-1:0]   w_t;
    logic                      w_unused_lsb;

    assign w_p = $signed(a) * $signed(b);
    assign w_m = w_p[2*FXP_W-1] ? 16'(-w_p) : w_p;

    // Integer part of the Q8.8 magnitude plus the half-LSB round bit.
    assign w_t = w_m[2*FXP_FRAC +: FXP_W] + {{(FXP_W-1){1'b0}}, w_m[2*FXP_FRAC-1]};
    assign y   = w_p[2*FXP_W-1] ? -w_t : w_t;

    assign w_unused_lsb = ^w_m[2*FXP_FRAC-2:0];

endmodule

// File: rtl/fxp_mul_arbiter.sv
// Round-robin arbiter sharing one Q4.4 multiplier among NREQ requesters, with
// a single tagged valid/ready response channel.
module fxp_mul_arbiter
    import fxp_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [FXP_W*NREQ-1:0] req_a,
    input  logic [FXP_W*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [FXP_W-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    state_e             r_state;
    logic [1:0]         r_last;
    logic [1:0]         r_idx;
    logic [FXP_W-1:0]   r_a;
    logic [FXP_W-1:0]   r_b;
    logic               r_rsp_valid;
    logic [FXP_W-1:0]   r_rsp_data;
    logic [IDW-1:0]     r_rsp_id;

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [1:0]         w_grant;
    logic               w_any;
    logic [FXP_W-1:0]   w_sel_a;
    logic [FXP_W-1:0]   w_sel_b;
    logic [FXP_W-1:0]   w_y;
    logic [NREQ-1:0]    w_ready;

    assign w_valid_ext = MAX_REQ'(req_valid);
    assign w_any       = |req_valid;
    assign w_grant     = rr_next(w_valid_ext, r_last, NREQ);

    // Only the granted lane reaches the operand registers, so X on idle lanes stays out.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (2'(i) == w_grant) begin
                w_sel_a = req_a[FXP_W*i +: FXP_W];
                w_sel_b = req_b[FXP_W*i +: FXP_W];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == IDLE && w_any && !rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (2'(i) == w_grant) begin
                    w_ready[i] = 1'b1;
                end
            end
        end
    end

    fxp_q44_mul_core u_core (
        .a (r_a),
        .b (r_b),
        .y (w_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 2'(NREQ - 1);
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_idx   <= w_grant;
                        r_last  <= w_grant;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rsp_data  <= w_y;
                    r_rsp_id    <= IDW'(r_idx);
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fxp_mul_arbiter.sv
// Self-checking bench for fxp_mul_arbiter: table-driven sweep, scoreboard on
// every response, plus arbitration, backpressure, reset and NREQ=4 sequences.
module tb_fxp_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    logic [3:0]  v4;
    logic [3:0]  rdy4;
    logic [31:0] a4;
    logic [31:0] b4;
    logic        rv4;
    logic        rr4;
    logic [7:0]  rd4;
    logic [1:0]  rid4;
    logic        busy4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    fxp_mul_arbiter #(.NREQ(2), .IDW(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    fxp_mul_arbiter #(.NREQ(4), .IDW(2)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v4),
        .req_ready (rdy4),
        .req_a     (a4),
        .req_b     (b4),
        .rsp_valid (rv4),
        .rsp_ready (rr4),
        .rsp_data  (rd4),
        .rsp_id    (rid4),
        .busy      (busy4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
        int p, m, t;
        p = int'($signed(a)) * int'($signed(b));
        m = (p < 0) ? -p : p;
        t = (m / 256) + ((m / 128) % 2);
        if (p < 0) t = -t;
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("ready_onehot", 32'($onehot0(req_ready)), 1);
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i] && req_valid[i])
                    sb_q.push_back({2'(i), model(req_a[i*8 +: 8], req_b[i*8 +: 8])});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_rsp: got data 0x%0h id %0d with nothing pending",
                             rsp_data, rsp_id);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(rsp_data), 32'(e.data));
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                end
            end
        end
    end

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 30 && idx < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (req_ready[i] && req_valid[i]) idx = i;
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: got no grant expected one within 30 cycles");
        end
    endtask

    task automatic wait_grant4(output int idx);
        idx = -1;
        for (int k = 0; k < 30 && idx < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (rdy4[i] && v4[i]) idx = i;
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL grant4_timeout: got no grant expected one within 30 cycles");
        end
    endtask

    // Single-requester transaction with latency and result checks.
    task automatic txn(input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input string tag);
        int g;
        @(posedge clk);
        #1;
        req_a[r*8 +: 8] = a;
        req_b[r*8 +: 8] = b;
        req_valid       = 2'b00;
        req_valid[r]    = 1'b1;
        wait_grant(g);
        chk({tag, "_grant"}, g, r);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk({tag, "_valid_t1"}, 32'(rsp_valid), 0);
        @(negedge clk);
        chk({tag, "_valid_t2"}, 32'(rsp_valid), 1);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
        chk({tag, "_id"}, 32'(rsp_id), r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int last_cyc;
        vecs[0] = '{8'hE8, 8'h28, 8'hFC};
        vecs[1] = '{8'h18, 8'h18, 8'h02};
        vecs[2] = '{8'h08, 8'h10, 8'h01};
        vecs[3] = '{8'h08, 8'hF0, 8'hFF};
        vecs[4] = '{8'h80, 8'h80, 8'h40};
        vecs[5] = '{8'h7F, 8'h7F, 8'h3F};

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        v4        = '0;
        a4        = '0;
        b4        = '0;
        rr4       = 1'b1;

        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_busy4", 32'(busy4), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        txn(0, 8'h18, 8'h28, 8'h04, "single0");
        for (int i = 0; i < 6; i++) txn(1, vecs[i].a, vecs[i].b, vecs[i].exp, "sweep");

        // Both continuously valid: strict alternation, one accept per 3 cycles.
        @(posedge clk);
        #1;
        req_a     = {8'h20, 8'h18};
        req_b     = {8'h30, 8'h28};
        req_valid = 2'b11;
        last_cyc  = 0;
        for (int n = 0; n < 6; n++) begin
            wait_grant(g);
            chk("rr_order", g, n % 2);
            if (n > 0) chk("rr_spacing", cyc - last_cyc, 3);
            last_cyc = cyc;
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);

        // Backpressure in RESP with another requester pending.
        #1;
        rsp_ready   = 1'b0;
        req_a[7:0]  = 8'h30;
        req_b[7:0]  = 8'h20;
        req_valid   = 2'b01;
        wait_grant(g);
        chk("bp_grant", g, 0);
        @(posedge clk);
        #1 req_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_data", 32'(rsp_data), 32'h06);
            chk("bp_hold_id", 32'(rsp_id), 0);
            chk("bp_hold_ready", 32'(req_ready), 0);
            chk("bp_hold_busy", 32'(busy), 1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", 32'(busy), 0);
        chk("bp_idle_valid", 32'(rsp_valid), 0);
        chk("bp_idle_ready", 32'(req_ready), 32'b10);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);

        // Reset while in CALC discards the transaction and restarts arbitration.
        #1;
        req_a     = {8'h10, 8'h10};
        req_b     = {8'h10, 8'h10};
        req_valid = 2'b11;
        wait_grant(g);
        chk("rstmid_grant", g, 0);
        @(negedge clk);
        chk("rstmid_busy_calc", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_rsp_data", 32'(rsp_data), 0);
        chk("rstmid_rsp_id", 32'(rsp_id), 0);
        chk("rstmid_ready", 32'(req_ready), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_first_grant", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);

        // NREQ=4 instance: rotation through all four, then a lone requester 2.
        #1;
        a4 = {8'h40, 8'h30, 8'h20, 8'h10};
        b4 = {4{8'h10}};
        v4 = 4'hF;
        for (int n = 0; n < 8; n++) begin
            wait_grant4(g);
            chk("rr4_order", g, n % 4);
        end
        @(posedge clk);
        #1 v4 = 4'b0100;
        wait_grant4(g);
        chk("rr4_only2", g, 2);
        @(posedge clk);
        #1 v4 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("rr4_rsp_valid", 32'(rv4), 1);
        chk("rr4_rsp_id", 32'(rid4), 2);
        chk("rr4_rsp_data", 32'(rd4), 32'(model(8'h30, 8'h10)));

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
